// File: rtl/mlp_pkg.sv
// Shared state encoding and default sizes for the MLP stream bridge.
package mlp_pkg;

  localparam int unsigned WORD_SIZE_DEF = 8;
  localparam int unsigned N_DEF         = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    DRAIN   = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/mlp_stream_bridge_argmax.sv
// Combinational comparator chain selecting the largest unsigned word (lowest index on ties).
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned N         = N_DEF
) (
  input  logic [N*WORD_SIZE-1:0]  words,
  output logic [$clog2(N)-1:0]    idx
);

  logic [WORD_SIZE-1:0] best;

  // Strict compare keeps the earlier index when words are equal.
  always_comb begin
    best = words[WORD_SIZE-1:0];
    idx  = '0;
    for (int unsigned i = 1; i < N; i++) begin
      if (words[i*WORD_SIZE +: WORD_SIZE] > best) begin
        best = words[i*WORD_SIZE +: WORD_SIZE];
        idx  = ($clog2(N))'(i);
      end
    end
  end

endmodule

// File: rtl/mlp_stream_bridge.sv
// Stream-to-parallel bridge around an MLP core: collect N words, launch, wait, drain N results.
// Optional m_argmax output is enabled with macro MLP_BRIDGE_ARGMAX_EN.
module mlp_stream_bridge
  import mlp_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = WORD_SIZE_DEF,
  parameter int unsigned N              = N_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WORD_SIZE-1:0]     s_data,
  output logic                     mlp_init,
  output logic [N*WORD_SIZE-1:0]   mlp_inputs,
  input  logic                     mlp_ready,
  input  logic [N*WORD_SIZE-1:0]   mlp_outputs,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WORD_SIZE-1:0]     m_data,
  output logic                     m_last,
  output logic                     timeout_err,
  output logic                     busy
`ifdef MLP_BRIDGE_ARGMAX_EN
  ,
  output logic [$clog2(N)-1:0]     m_argmax
`endif
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

  bridge_state_t          state;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic [N*WORD_SIZE-1:0] inputs_q;
  logic [N*WORD_SIZE-1:0] result_q;
  logic                   live;
  logic                   in_beat;

  // live holds s_ready low while in reset and rises on the first clock after release.
  assign in_beat = (state == COLLECT) && live && s_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= COLLECT;
      idx      <= '0;
      cnt      <= '0;
      inputs_q <= '0;
      result_q <= '0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        COLLECT: begin
          if (in_beat) begin
            inputs_q[idx*WORD_SIZE +: WORD_SIZE] <= s_data;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= LAUNCH;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mlp_ready) begin
            result_q <= mlp_outputs;
            state    <= DRAIN;
          end else if (cnt == CNT_MAX) begin
            state <= COLLECT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= COLLECT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign s_ready    = (state == COLLECT) && live;
  assign mlp_init   = (state == LAUNCH);
  assign mlp_inputs = inputs_q;
  assign m_valid    = (state == DRAIN);
  assign m_data     = m_valid ? result_q[idx*WORD_SIZE +: WORD_SIZE] : '0;
  assign m_last     = m_valid && (idx == LAST_IDX);
  assign busy       = (state != COLLECT);
  // Decoded in the final WAIT cycle itself so a same-cycle mlp_ready can suppress it.
  assign timeout_err = (state == WAIT) && (cnt == CNT_MAX) && !mlp_ready;

`ifdef MLP_BRIDGE_ARGMAX_EN
  logic [IW-1:0] argmax_next;
  logic [IW-1:0] argmax_q;

  mlp_argmax #(
    .WORD_SIZE(WORD_SIZE),
    .N        (N)
  ) u_argmax (
    .words(mlp_outputs),
    .idx  (argmax_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      argmax_q <= '0;
    end else if ((state == WAIT) && mlp_ready) begin
      argmax_q <= argmax_next;
    end
  end

  assign m_argmax = argmax_q;
`endif

endmodule

// File: tb/tb_mlp_stream_bridge.sv
// Directed + randomized bench for mlp_stream_bridge with a behavioural MLP core model.
module tb_mlp_stream_bridge;

  localparam int unsigned W  = 8;
  localparam int unsigned NN = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          mlp_init;
  logic [15:0]   mlp_inputs;
  logic          mlp_ready;
  logic [15:0]   mlp_outputs;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          timeout_err;
  logic          busy;
`ifdef MLP_BRIDGE_ARGMAX_EN
  logic [0:0]    m_argmax;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int init_count = 0;
  int to_count   = 0;
  int pend = 0;

  logic [15:0] core_resp = '0;
  bit          core_en   = 1'b1;
  int          core_lat  = 6;
  bit          spur_req  = 1'b0;
  bit          spur_seen = 1'b0;

  mlp_stream_bridge #(
    .WORD_SIZE     (W),
    .N             (NN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mlp_init   (mlp_init),
    .mlp_inputs (mlp_inputs),
    .mlp_ready  (mlp_ready),
    .mlp_outputs(mlp_outputs),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .timeout_err(timeout_err),
    .busy       (busy)
`ifdef MLP_BRIDGE_ARGMAX_EN
    ,
    .m_argmax   (m_argmax)
`endif
  );

  always #5 clk = ~clk;

  // Core model: answers core_lat cycles after seeing mlp_init; garbage on the result bus otherwise.
  always begin
    @(posedge clk);
    #1;
    mlp_ready   = 1'b0;
    mlp_outputs = 16'($urandom);
    if (!n_rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mlp_ready   = 1'b1;
          mlp_outputs = core_resp;
        end
      end
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        mlp_ready = 1'b1;
      end
      if (mlp_init && core_en) pend = core_lat;
    end
  end

  always @(posedge clk) begin
    if (mlp_init)    init_count++;
    if (timeout_err) to_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"},     32'(s_ready),     0);
    chk({tag, "_mlp_init"},    32'(mlp_init),    0);
    chk({tag, "_m_valid"},     32'(m_valid),     0);
    chk({tag, "_m_last"},      32'(m_last),      0);
    chk({tag, "_m_data"},      32'(m_data),      0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_busy"},        32'(busy),        0);
    chk({tag, "_mlp_inputs"},  32'(mlp_inputs),  0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("rel_s_ready_before_edge", 32'(s_ready), 0);
    @(negedge clk);
    chk("rel_s_ready_after_edge", 32'(s_ready), 1);
    chk("rel_busy", 32'(busy), 0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = W'($urandom);
    chk("s_accept", 32'(ok), 1);
  endtask

  // Sends a,b; ends at the negedge of the LAUNCH cycle after checking it.
  task automatic collect_and_launch(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    send_word(a, 0);
    send_word(b, gap);
    @(negedge clk);
    chk("launch_init",    32'(mlp_init),   1);
    chk("launch_inputs",  32'(mlp_inputs), 32'({b, a}));
    chk("launch_s_ready", 32'(s_ready),    0);
    chk("launch_busy",    32'(busy),       1);
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                         input logic [15:0] resp, input int lat, input int stall,
                         input int sbeat, input bit spur_drain);
    logic [W-1:0] exp_w [2];
    int init0, to0, n, bt, s, g;
    logic exp_am;
    exp_w[0] = resp[7:0];
    exp_w[1] = resp[15:8];
    exp_am   = (resp[15:8] > resp[7:0]) ? 1'b1 : 1'b0;
    core_resp = resp;
    core_lat  = lat;
    core_en   = 1'b1;
    collect_and_launch(a, b, gap);
    init0 = init_count;
    to0   = to_count;
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (!m_valid) chk("wait_no_timeout", 32'(timeout_err), 0);
    end
    chk("drain_latency", 32'(n), 32'(lat + 1));
    if (spur_drain) spur_req = ~spur_req;
    bt = 0;
    s  = 0;
    g  = 0;
    while (bt < 2 && g < 50) begin
      chk("drain_valid", 32'(m_valid), 1);
      chk("drain_data",  32'(m_data),  32'(exp_w[bt]));
      chk("drain_last",  32'(m_last),  32'(bt == 1));
`ifdef MLP_BRIDGE_ARGMAX_EN
      if (bt == 1) chk("argmax", 32'(m_argmax), 32'(exp_am));
`endif
      if (bt == sbeat && s < stall) begin
        m_ready = 1'b0;
        s++;
      end else begin
        m_ready = 1'b1;
        bt++;
      end
      @(negedge clk);
      g++;
    end
    m_ready = 1'b0;
    chk("done_m_valid",    32'(m_valid),    0);
    chk("done_s_ready",    32'(s_ready),    1);
    chk("done_busy",       32'(busy),       0);
    chk("done_inputs",     32'(mlp_inputs), 32'({b, a}));
    chk("done_init_count", 32'(init_count), 32'(init0 + 1));
    chk("done_to_count",   32'(to_count),   32'(to0));
  endtask

  initial begin
    int init0, to0;
    // Power-on reset
    repeat (2) @(negedge clk);
    chk_reset("por");
    release_reset();

    // Basic transfer: m_ready high, core answers after 6 cycles
    m_ready = 1'b1;
    run_txn(8'h05, 8'h07, 0, 16'h2211, 6, 0, 0, 1'b0);

    // Gapped input, 3-cycle stall on the first drain beat, ignored pulse during DRAIN
    run_txn(8'hA3, 8'h5C, 3, 16'h9ABC, 3, 3, 0, 1'b1);

    // Timeout: core never answers
    core_en = 1'b0;
    collect_and_launch(8'h12, 8'h34, 0);
    to0 = to_count;
    for (int c = 1; c <= int'(TO); c++) begin
      @(negedge clk);
      chk("to_pulse", 32'(timeout_err), 32'(c == int'(TO)));
      chk("to_busy",  32'(busy), 1);
    end
    @(negedge clk);
    chk("to_after_s_ready", 32'(s_ready),     1);
    chk("to_after_busy",    32'(busy),        0);
    chk("to_after_err",     32'(timeout_err), 0);
    chk("to_after_m_valid", 32'(m_valid),     0);
    chk("to_count",         32'(to_count),    32'(to0 + 1));

    // mlp_ready in the timeout cycle wins
    run_txn(8'h01, 8'h02, 0, 16'h4433, int'(TO), 0, 0, 1'b0);

    // Reset in WAIT
    core_en  = 1'b1;
    core_lat = 20;
    collect_and_launch(8'h66, 8'h77, 0);
    repeat (3) @(negedge clk);
    init0 = init_count;
    to0   = to_count;
    n_rst = 1'b0;
    #1;
    chk_reset("rst_wait");
    repeat (3) @(negedge clk);
    chk_reset("rst_wait_hold");
    release_reset();
    repeat (4) @(negedge clk);
    chk("rst_wait_init", 32'(init_count), 32'(init0));
    chk("rst_wait_to",   32'(to_count),   32'(to0));

    // Reset in DRAIN
    core_lat = 4;
    core_resp = 16'hBEEF;
    collect_and_launch(8'h88, 8'h99, 0);
    repeat (20) begin
      if (!m_valid) @(negedge clk);
    end
    chk("rst_drain_entered", 32'(m_valid), 1);
    init0 = init_count;
    to0   = to_count;
    n_rst = 1'b0;
    #1;
    chk_reset("rst_drain");
    repeat (2) @(negedge clk);
    release_reset();
    repeat (3) @(negedge clk);
    chk("rst_drain_init", 32'(init_count), 32'(init0));
    chk("rst_drain_to",   32'(to_count),   32'(to0));
    run_txn(8'hC1, 8'hD2, 1, 16'h5A6B, 5, 1, 1, 1'b0);

    // Argmax tie and clear winner
    run_txn(8'h0F, 8'hF0, 0, 16'h3030, 2, 0, 0, 1'b0);
    run_txn(8'h0E, 8'hE0, 0, 16'h4010, 2, 0, 0, 1'b0);

    // Randomized transfers with ignored mlp_ready pulses while idle
    for (int t = 0; t < 6; t++) begin
      spur_req = ~spur_req;
      repeat (2) @(negedge clk);
      chk("idle_spur_busy",    32'(busy),    0);
      chk("idle_spur_s_ready", 32'(s_ready), 1);
      run_txn(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 16'($urandom),
              int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_stream_bridge.md
MLP_STREAM_BRIDGE -- requirements
Module: mlp_stream_bridge

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 8, word width; N, default 2, layer width (N >= 2); TIMEOUT_CYCLES, default 1024, WAIT-state limit (>= 2).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- s_valid  in  1  input word valid
- s_ready  out  1  input word accept
- s_data  in  WORD_SIZE  input word
- mlp_init  out  1  start pulse to MLP core
- mlp_inputs  out  WORD_SIZE x N  parallel input vector to MLP core
- mlp_ready  in  1  one-cycle completion pulse from MLP core
- mlp_outputs  in  WORD_SIZE x N  MLP result vector
- m_valid  out  1  output word valid
- m_ready  in  1  output word accept
- m_data  out  WORD_SIZE  output word
- m_last  out  1  marks word N-1
- timeout_err  out  1  one-cycle pulse on WAIT timeout
- busy  out  1  high in any state except COLLECT

Function
REQ-003 The FSM SHALL have the states COLLECT, LAUNCH, WAIT and DRAIN.
REQ-004 COLLECT: s_ready=1; each s_valid&s_ready beat SHALL write s_data to mlp_inputs[idx] and then increment idx; the beat at idx=N-1 SHALL go to LAUNCH and clear idx.
REQ-005 LAUNCH SHALL last exactly one cycle with mlp_init=1, then go to WAIT; the first s_data word SHALL be mlp_inputs[0].
REQ-006 mlp_inputs SHALL stay stable from LAUNCH until the next COLLECT write; s_ready SHALL be 0 outside COLLECT.
REQ-007 WAIT: a cycle counter SHALL start at 0 and increment each cycle; mlp_ready=1 SHALL capture mlp_outputs into an internal result register that same cycle and go to DRAIN.
REQ-008 WAIT: if the counter equals TIMEOUT_CYCLES-1 and mlp_ready=0, timeout_err SHALL pulse for one cycle and the FSM SHALL go to COLLECT, discarding the result.
REQ-009 If mlp_ready=1 in the same cycle as the timeout condition, mlp_ready SHALL win and no timeout_err SHALL be raised.
REQ-010 mlp_ready outside WAIT SHALL be ignored.
REQ-011 DRAIN: m_valid=1 and m_data=result[idx]; m_valid&m_ready SHALL increment idx; m_last=1 only when idx=N-1.
REQ-012 The final DRAIN beat SHALL return to COLLECT with idx=0, so s_ready=1 in the next cycle.
REQ-013 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0; m_valid SHALL be 0 outside DRAIN.
REQ-014 Minimum turnaround SHALL be N (collect) + 1 (launch) + core latency + N (drain) cycles.
REQ-015 All outputs SHALL be registered or decoded from state and idx only; there SHALL be no combinational path from s_valid to s_ready or from m_ready to m_valid.

Reset
REQ-016 When n_rst=0 the block SHALL enter COLLECT and clear idx, the counter, mlp_inputs and the result register.
REQ-017 During reset: s_ready=0, then 1 in the first cycle after release; mlp_init=0, m_valid=0, m_last=0, m_data=0, timeout_err=0, busy=0.
REQ-018 Reset mid-operation in any state SHALL abandon the transfer, with no pulse on mlp_init or timeout_err.

Configuration
REQ-019 With macro MLP_BRIDGE_ARGMAX_EN defined, output port m_argmax (width $clog2(N)) SHALL be added and SHALL be valid with m_last.
REQ-020 m_argmax SHALL be the index of the largest unsigned result word, computed at capture; ties SHALL go to the lowest index.
REQ-021 With MLP_BRIDGE_ARGMAX_EN undefined, the m_argmax port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 Package mlp_pkg SHALL hold the state enum bridge_state_t and the shared WORD_SIZE/N defaults.
REQ-023 Sub-module mlp_argmax (combinational comparator tree) SHALL be instantiated only under MLP_BRIDGE_ARGMAX_EN.

Verification
REQ-024 The bench SHALL cover these scenarios:
- N=2; send 0x05, 0x07 with m_ready=1; core model answers mlp_ready after 6 cycles with {0x11, 0x22} -> mlp_inputs={0x05,0x07}; mlp_init exactly one pulse; m_data 0x11 then 0x22; m_last on the 2nd beat.
- Gap s_valid between beats; hold m_ready=0 for 3 cycles in DRAIN -> no lost or duplicated words; m_data held stable.
- TIMEOUT_CYCLES=16; core never answers -> timeout_err pulses at the 16th WAIT cycle; s_ready=1 the next cycle.
- mlp_ready asserted in the timeout cycle -> DRAIN entered, timeout_err stays 0.
- Assert n_rst in WAIT and in DRAIN -> all outputs at reset values; a fresh transfer then completes correctly.
- ARGMAX_EN defined, results {0x30, 0x30} -> m_argmax=0; results {0x10, 0x40} -> m_argmax=1.
